// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/sub opcodes, flag bundle and operand-conditioning helpers.
package alu_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned FLAGS_W = 4;

  typedef enum logic [OP_W-1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    ADC = 2'b10,
    SBC = 2'b11
  } op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Subtractions feed the inverted B operand into the adder
  function automatic logic op_inverts_b(input op_t op);
    return (op == SUB) || (op == SBC);
  endfunction

  // Carry into the low chunk: fixed for ADD/SUB, the flag input for ADC/SBC
  function automatic logic eff_cin(input op_t op, input logic cin);
    logic c;
    case (op)
      ADD:     c = 1'b0;
      SUB:     c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle between operand fetch and writeback.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_t              op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, r, flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, r, flag_n, flag_z, flag_c, flag_v
  );

endinterface

// File: rtl/pipelined_addsub_chunk.sv
// One CW-bit slice of the adder: sum, carry out and a zero bit for the slice.
module addsub_chunk #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          zero
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (CW+1)'(cin);
  assign zero        = (sum == '0);

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub: chunk k of the sum is resolved in stage k with the carry
// registered between stages; a single stall signal freezes the whole pipe.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  pipelined_addsub_if.slave bus
);

  localparam int unsigned CW = WIDTH / STAGES;
  localparam int unsigned L  = STAGES - 1;

  logic                           advance;
  logic [STAGES-1:0]              v_q, c_q, z_q;
  logic [STAGES-1:0][WIDTH-1:0]   a_q, b_q, s_q;
  logic [STAGES-1:0]              iv, ic, iz, co, zo;
  logic [STAGES-1:0][WIDTH-1:0]   ia, ib, is, ns;
  logic [WIDTH-1:0]               csum;
  flags_t                         fl;

  assign advance = !(bus.out_valid && !bus.out_ready);

  // Stage inputs: stage 0 takes the conditioned operands, others the previous stage
  always_comb begin
    iv = '0;
    ic = '0;
    iz = '0;
    ia = '0;
    ib = '0;
    is = '0;
    iv[0] = bus.in_valid;
    ia[0] = bus.a;
    ib[0] = op_inverts_b(bus.op) ? ~bus.b : bus.b;
    ic[0] = eff_cin(bus.op, bus.cin);
    iz[0] = 1'b1;
    for (int unsigned k = 1; k < STAGES; k++) begin
      iv[k] = v_q[k-1];
      ia[k] = a_q[k-1];
      ib[k] = b_q[k-1];
      ic[k] = c_q[k-1];
      iz[k] = z_q[k-1];
      is[k] = s_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_chunk #(.CW(CW)) u_chunk (
      .a    (ia[k][k*CW +: CW]),
      .b    (ib[k][k*CW +: CW]),
      .cin  (ic[k]),
      .sum  (csum[k*CW +: CW]),
      .cout (co[k]),
      .zero (zo[k])
    );
  end

  // Merge each stage's freshly computed chunk into the partial sum it carries
  always_comb begin
    ns = is;
    for (int unsigned k = 0; k < STAGES; k++) begin
      ns[k][k*CW +: CW] = csum[k*CW +: CW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      z_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else if (advance) begin
      v_q <= iv;
      c_q <= co;
      z_q <= iz & zo;
      a_q <= ia;
      b_q <= ib;
      s_q <= ns;
    end
  end

  // Overflow: operands agree in sign (after B conditioning) but the result does not
  always_comb begin
    fl.n = s_q[L][WIDTH-1];
    fl.z = z_q[L];
    fl.c = c_q[L];
    fl.v = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[L];
  assign bus.r         = s_q[L];
  assign bus.flag_n    = fl.n;
  assign bus.flag_z    = fl.z;
  assign bus.flag_c    = fl.c;
  assign bus.flag_v    = fl.v;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed corners, randomized stream with stall,
// reset flush, and 16/64-bit instances at STAGES 1, 2 and 8.
module tb_pipelined_addsub;
  import alu_pkg::*;

  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(32)) bus ();
  pipelined_addsub_if #(.WIDTH(16)) b1  ();
  pipelined_addsub_if #(.WIDTH(16)) b2  ();
  pipelined_addsub_if #(.WIDTH(64)) b8  ();

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut    (.clk(clk), .rst(rst), .bus(bus.slave));
  pipelined_addsub #(.WIDTH(16), .STAGES(1)) dut_s1 (.clk(clk), .rst(rst), .bus(b1.slave));
  pipelined_addsub #(.WIDTH(16), .STAGES(2)) dut_s2 (.clk(clk), .rst(rst), .bus(b2.slave));
  pipelined_addsub #(.WIDTH(64), .STAGES(8)) dut_s8 (.clk(clk), .rst(rst), .bus(b8.slave));

  int checks = 0;
  int errors = 0;
  logic [35:0] expq[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed views of the operands
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input op_t op, input logic cin);
    longint ua, ub, sa, sb, ut, st, k;
    logic c, v;
    logic [31:0] r;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == ADD || op == ADC) begin
      k  = (op == ADC) ? longint'(cin) : 64'sd0;
      ut = ua + ub + k;
      st = sa + sb + k;
      c  = (ut >= 64'sd4294967296);
    end else begin
      k  = (op == SBC) ? longint'(!cin) : 64'sd0;
      ut = ua - ub - k;
      st = sa - sb - k;
      c  = (ua >= ub + k);
    end
    r = ut[31:0];
    v = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input op_t iop, input logic ic, input logic ordy);
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.op        = iop;
    bus.cin       = ic;
    bus.out_ready = ordy;
    #1;
  endtask

  function automatic logic [35:0] obs32();
    return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v, bus.r};
  endfunction

  // One scoreboarded cycle on the 32-bit instance
  task automatic sb_step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                         input op_t iop, input logic ic, input logic ordy, output logic acc);
    drive(iv, ia, ib, iop, ic, ordy);
    if (bus.out_valid === 1'b1) begin
      if (expq.size() == 0) chk("extra_output", bus.out_valid, 1'b0);
      else begin
        chk(ordy ? "stream_result" : "held_result", obs32(), expq[0]);
        if (ordy) void'(expq.pop_front());
      end
    end
    acc = iv && (bus.in_ready === 1'b1);
    if (acc) expq.push_back(model(ia, ib, iop, ic));
    tick();
  endtask

  task automatic run_one(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input op_t iop, input logic ic, input logic [35:0] exp);
    int lat;
    lat = 0;
    drive(1'b1, ia, ib, iop, ic, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, ADD, 1'b0, 1'b1);
    for (int n = 1; n <= 20; n++) begin
      if (bus.out_valid === 1'b1) begin
        lat = n;
        break;
      end
      tick();
    end
    chk({tag, "_latency"}, lat, S);
    chk({tag, "_value"}, obs32(), exp);
    tick();
    chk({tag, "_single_beat"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    logic        acc;
    logic [31:0] ta, tb;
    op_t         top;
    logic        tc;
    int          sent, l1, l2, l8;

    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, ADD, 1'b0, 1'b1);
    b1.in_valid = 1'b0; b1.out_ready = 1'b1; b1.a = '0; b1.b = '0; b1.op = ADD; b1.cin = 1'b0;
    b2.in_valid = 1'b0; b2.out_ready = 1'b1; b2.a = '0; b2.b = '0; b2.op = ADD; b2.cin = 1'b0;
    b8.in_valid = 1'b0; b8.out_ready = 1'b1; b8.a = '0; b8.b = '0; b8.op = ADD; b8.cin = 1'b0;
    tick();
    tick();
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_r_flags", obs32(), 36'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_in_ready", bus.in_ready, 1'b1);

    run_one("add_5_3",     32'h0000_0005, 32'h0000_0003, ADD, 1'b0, {4'b0000, 32'h0000_0008});
    run_one("sub_3_5",     32'h0000_0003, 32'h0000_0005, SUB, 1'b0, {4'b1000, 32'hFFFF_FFFE});
    run_one("sub_5_5",     32'h0000_0005, 32'h0000_0005, SUB, 1'b0, {4'b0110, 32'h0000_0000});
    run_one("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, ADD, 1'b0, {4'b1001, 32'h8000_0000});
    run_one("adc_ripple",  32'hFFFF_FFFF, 32'h0000_0000, ADC, 1'b1, {4'b0110, 32'h0000_0000});
    run_one("sbc_zero",    32'h0000_0000, 32'h0000_0000, SBC, 1'b0, {4'b1000, 32'hFFFF_FFFF});
    run_one("sbc_ovf",     32'h8000_0000, 32'h0000_0000, SBC, 1'b0, {4'b0011, 32'h7FFF_FFFF});

    // Randomized back-to-back stream with a three-cycle consumer stall mid-stream
    sent = 0;
    ta = $urandom; tb = $urandom; top = op_t'(2'($urandom_range(0, 3))); tc = 1'($urandom_range(0, 1));
    for (int i = 0; i < 40 && sent < 8; i++) begin
      if (i >= 5 && i <= 7) begin
        drive(1'b1, ta, tb, top, tc, 1'b0);
        chk("stall_in_ready", bus.in_ready, 1'b0);
        chk("stall_out_valid", bus.out_valid, 1'b1);
        sb_step(1'b1, ta, tb, top, tc, 1'b0, acc);
      end else begin
        sb_step(1'b1, ta, tb, top, tc, 1'b1, acc);
      end
      if (acc) begin
        sent++;
        ta = $urandom; tb = $urandom; top = op_t'(2'($urandom_range(0, 3))); tc = 1'($urandom_range(0, 1));
      end
    end
    chk("stream_sent", sent, 8);
    for (int i = 0; i < 20 && expq.size() != 0; i++) sb_step(1'b0, 32'd0, 32'd0, ADD, 1'b0, 1'b1, acc);
    chk("stream_drained", expq.size(), 0);
    sb_step(1'b0, 32'd0, 32'd0, ADD, 1'b0, 1'b1, acc);

    // Reset with three tokens in flight: none of them may emerge
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i + 100), 32'd7, ADD, 1'b0, 1'b1);
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, ADD, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("flush_no_output", bus.out_valid, 1'b0);
      tick();
    end
    run_one("add_1_1", 32'd1, 32'd1, ADD, 1'b0, {4'b0000, 32'd2});

    // Other geometries: SBC 0-0 with no carry in on all three, latency = STAGES
    b1.in_valid = 1'b1; b1.op = SBC; b1.a = '0; b1.b = '0; b1.cin = 1'b0;
    b2.in_valid = 1'b1; b2.op = SBC; b2.a = '0; b2.b = '0; b2.cin = 1'b0;
    b8.in_valid = 1'b1; b8.op = SBC; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
    tick();
    b1.in_valid = 1'b0; b2.in_valid = 1'b0; b8.in_valid = 1'b0;
    l1 = 0; l2 = 0; l8 = 0;
    for (int n = 1; n <= 20; n++) begin
      if (l1 == 0 && b1.out_valid === 1'b1) begin
        l1 = n;
        chk("s1_sbc_value", {b1.flag_n, b1.flag_z, b1.flag_c, b1.flag_v, b1.r}, {4'b1000, 16'hFFFF});
      end
      if (l2 == 0 && b2.out_valid === 1'b1) begin
        l2 = n;
        chk("s2_sbc_value", {b2.flag_n, b2.flag_z, b2.flag_c, b2.flag_v, b2.r}, {4'b1000, 16'hFFFF});
      end
      if (l8 == 0 && b8.out_valid === 1'b1) begin
        l8 = n;
        chk("s8_sbc_value", {b8.flag_n, b8.flag_z, b8.flag_c, b8.flag_v, b8.r}, {4'b1000, 64'hFFFF_FFFF_FFFF_FFFF});
      end
      if (l1 != 0 && l2 != 0 && l8 != 0) break;
      tick();
    end
    chk("s1_latency", l1, 1);
    chk("s2_latency", l2, 2);
    chk("s8_latency", l8, 8);

    // 64-bit carry ripple through all eight chunks
    tick();
    b8.in_valid = 1'b1; b8.op = ADC; b8.a = 64'hFFFF_FFFF_FFFF_FFFF; b8.b = '0; b8.cin = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    l8 = 0;
    for (int n = 1; n <= 20; n++) begin
      if (b8.out_valid === 1'b1) begin
        l8 = n;
        break;
      end
      tick();
    end
    chk("s8_adc_latency", l8, 8);
    chk("s8_adc_value", {b8.flag_n, b8.flag_z, b8.flag_c, b8.flag_v, b8.r}, {4'b0110, 64'd0});

    // Single-stage pipe sustains full rate with no gaps
    tick();
    for (int i = 0; i < 4; i++) begin
      b1.in_valid = 1'b1; b1.op = ADD; b1.a = 16'(i * 1000); b1.b = 16'd1; b1.cin = 1'b0;
      tick();
      chk("s1_b2b_valid", b1.out_valid, 1'b1);
      chk("s1_b2b_value", b1.r, 16'(i * 1000 + 1));
    end
    b1.in_valid = 1'b0;
    tick();
    chk("s1_b2b_end", b1.out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
